// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the register file's two read ports between operand collectors,
// tracking in-flight reads with a tag pipeline and steering the returning valid strobes.
module rf_read_arbiter #(
    parameter int unsigned NUM_CU     = 4,
    parameter int unsigned RF_LATENCY = 2,
    parameter int unsigned WARP_ID_W  = 5,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CU-1:0]                i_cu_req_valid,
    input  logic [NUM_CU*WARP_ID_W-1:0]      i_cu_warp_id,
    input  logic [NUM_CU-1:0]                i_cu_rs1_en,
    input  logic [NUM_CU*REG_ADDR_W-1:0]     i_cu_rs1_addr,
    input  logic [NUM_CU-1:0]                i_cu_rs2_en,
    input  logic [NUM_CU*REG_ADDR_W-1:0]     i_cu_rs2_addr,
    output logic [NUM_CU-1:0]                o_cu_grant,
    output logic [NUM_CU-1:0]                o_cu_rs1_valid,
    output logic [NUM_CU-1:0]                o_cu_rs2_valid,
    output logic [WARP_ID_W-1:0]             o_rf_warp_id,
    output logic                             o_rf_rs1_req,
    output logic [REG_ADDR_W-1:0]            o_rf_rs1_addr,
    output logic                             o_rf_rs2_req,
    output logic [REG_ADDR_W-1:0]            o_rf_rs2_addr,
    input  logic                             i_rf_rs1_valid,
    input  logic                             i_rf_rs2_valid,
    output logic                             o_err
);

    localparam int unsigned PTR_W = $clog2(NUM_CU);

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
        logic             rs1_en;
        logic             rs2_en;
    } tag_t;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NUM_CU-1:0]     r_busy;
    tag_t                  r_tag [0:RF_LATENCY];

    logic [NUM_CU-1:0]     w_eligible;
    logic                  w_win_found;
    logic [PTR_W-1:0]      w_win_idx;
    logic [PTR_W-1:0]      w_cand;
    logic [WARP_ID_W-1:0]  w_win_warp;
    logic                  w_win_rs1_en;
    logic                  w_win_rs2_en;
    logic [REG_ADDR_W-1:0] w_win_rs1_addr;
    logic [REG_ADDR_W-1:0] w_win_rs2_addr;
    tag_t                  w_tag_out;
    logic                  w_err_event;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_CU) s = s - NUM_CU;
        return PTR_W'(s);
    endfunction

    // A collector just granted or still waiting on its returns cannot win.
    assign w_eligible = i_cu_req_valid & ~r_busy & ~o_cu_grant;

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < NUM_CU; k++) begin
            w_cand = wrap_idx(r_rr_ptr, k);
            if (!w_win_found && w_eligible[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // Select the winning collector's request fields.
    always_comb begin
        w_win_warp     = '0;
        w_win_rs1_en   = 1'b0;
        w_win_rs2_en   = 1'b0;
        w_win_rs1_addr = '0;
        w_win_rs2_addr = '0;
        for (int unsigned i = 0; i < NUM_CU; i++) begin
            if (w_win_idx == PTR_W'(i)) begin
                w_win_warp     = i_cu_warp_id[i*WARP_ID_W +: WARP_ID_W];
                w_win_rs1_en   = i_cu_rs1_en[i];
                w_win_rs2_en   = i_cu_rs2_en[i];
                w_win_rs1_addr = i_cu_rs1_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_win_rs2_addr = i_cu_rs2_addr[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

    assign w_tag_out = r_tag[RF_LATENCY];

    // Return strobes must line up exactly with the tag leaving the pipeline.
    assign w_err_event = (i_rf_rs1_valid != (w_tag_out.valid & w_tag_out.rs1_en)) |
                         (i_rf_rs2_valid != (w_tag_out.valid & w_tag_out.rs2_en));

    always_comb begin
        o_cu_rs1_valid = '0;
        o_cu_rs2_valid = '0;
        for (int unsigned i = 0; i < NUM_CU; i++) begin
            if (w_tag_out.valid && (w_tag_out.idx == PTR_W'(i))) begin
                o_cu_rs1_valid[i] = i_rf_rs1_valid & w_tag_out.rs1_en;
                o_cu_rs2_valid[i] = i_rf_rs2_valid & w_tag_out.rs2_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_busy        <= '0;
            o_cu_grant    <= '0;
            o_rf_warp_id  <= '0;
            o_rf_rs1_req  <= 1'b0;
            o_rf_rs1_addr <= '0;
            o_rf_rs2_req  <= 1'b0;
            o_rf_rs2_addr <= '0;
            o_err         <= 1'b0;
            for (int unsigned k = 0; k <= RF_LATENCY; k++) r_tag[k] <= '0;
        end else begin
            o_cu_grant   <= '0;
            o_rf_rs1_req <= 1'b0;
            o_rf_rs2_req <= 1'b0;
            r_tag[0]     <= '0;
            for (int unsigned k = 1; k <= RF_LATENCY; k++) r_tag[k] <= r_tag[k-1];
            if (w_tag_out.valid) r_busy[w_tag_out.idx] <= 1'b0;
            if (w_win_found) begin
                o_cu_grant[w_win_idx] <= 1'b1;
                o_rf_warp_id          <= w_win_warp;
                o_rf_rs1_req          <= w_win_rs1_en;
                o_rf_rs1_addr         <= w_win_rs1_addr;
                o_rf_rs2_req          <= w_win_rs2_en;
                o_rf_rs2_addr         <= w_win_rs2_addr;
                r_rr_ptr              <= wrap_idx(w_win_idx, 1);
                if (w_win_rs1_en || w_win_rs2_en) begin
                    r_busy[w_win_idx] <= 1'b1;
                    r_tag[0]          <= '{valid: 1'b1, idx: w_win_idx,
                                           rs1_en: w_win_rs1_en, rs2_en: w_win_rs2_en};
                end
            end
            if (w_err_event) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter with a fixed-latency register file return model.
module tb_rf_read_arbiter;

    localparam int unsigned NCU = 4;
    localparam int unsigned LAT = 2;
    localparam int unsigned WW  = 5;
    localparam int unsigned AW  = 5;

    logic              clk;
    logic              rst_n;
    logic [NCU-1:0]    cu_req_valid;
    logic [NCU*WW-1:0] cu_warp_id;
    logic [NCU-1:0]    cu_rs1_en;
    logic [NCU*AW-1:0] cu_rs1_addr;
    logic [NCU-1:0]    cu_rs2_en;
    logic [NCU*AW-1:0] cu_rs2_addr;
    logic [NCU-1:0]    cu_grant;
    logic [NCU-1:0]    cu_rs1_valid;
    logic [NCU-1:0]    cu_rs2_valid;
    logic [WW-1:0]     rf_warp_id;
    logic              rf_rs1_req;
    logic [AW-1:0]     rf_rs1_addr;
    logic              rf_rs2_req;
    logic [AW-1:0]     rf_rs2_addr;
    logic              rf_rs1_valid;
    logic              rf_rs2_valid;
    logic              err;

    logic [LAT-1:0]    d1, d2;
    logic              inj1, inj2, sup1, sup2;
    int                total;
    int                bad;

    rf_read_arbiter #(.NUM_CU(NCU), .RF_LATENCY(LAT), .WARP_ID_W(WW), .REG_ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cu_req_valid (cu_req_valid),
        .i_cu_warp_id   (cu_warp_id),
        .i_cu_rs1_en    (cu_rs1_en),
        .i_cu_rs1_addr  (cu_rs1_addr),
        .i_cu_rs2_en    (cu_rs2_en),
        .i_cu_rs2_addr  (cu_rs2_addr),
        .o_cu_grant     (cu_grant),
        .o_cu_rs1_valid (cu_rs1_valid),
        .o_cu_rs2_valid (cu_rs2_valid),
        .o_rf_warp_id   (rf_warp_id),
        .o_rf_rs1_req   (rf_rs1_req),
        .o_rf_rs1_addr  (rf_rs1_addr),
        .o_rf_rs2_req   (rf_rs2_req),
        .o_rf_rs2_addr  (rf_rs2_addr),
        .i_rf_rs1_valid (rf_rs1_valid),
        .i_rf_rs2_valid (rf_rs2_valid),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: a request in cycle c returns its strobe in cycle c+LAT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= {d1[LAT-2:0], rf_rs1_req};
            d2 <= {d2[LAT-2:0], rf_rs2_req};
        end
    end
    assign rf_rs1_valid = (d1[LAT-1] & ~sup1) | inj1;
    assign rf_rs2_valid = (d2[LAT-1] & ~sup2) | inj2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cu(input int i, input logic req, input logic [WW-1:0] w,
                          input logic e1, input logic [AW-1:0] a1,
                          input logic e2, input logic [AW-1:0] a2);
        cu_req_valid[i]       = req;
        cu_warp_id[i*WW +: WW] = w;
        cu_rs1_en[i]          = e1;
        cu_rs1_addr[i*AW +: AW] = a1;
        cu_rs2_en[i]          = e2;
        cu_rs2_addr[i*AW +: AW] = a2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_idx;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cu_req_valid = '0; cu_warp_id = '0; cu_rs1_en = '0; cu_rs1_addr = '0;
        cu_rs2_en = '0; cu_rs2_addr = '0;
        inj1 = 1'b0; inj2 = 1'b0; sup1 = 1'b0; sup2 = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_grant", 64'(cu_grant), 64'(0));
        chk("rst_rs1_req", 64'(rf_rs1_req), 64'(0));
        chk("rst_rs2_req", 64'(rf_rs2_req), 64'(0));
        chk("rst_warp", 64'(rf_warp_id), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        step();

        // Single request from collector 0
        set_cu(0, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd7);
        step();
        chk("single_grant", 64'(cu_grant), 64'(4'b0001));
        chk("single_rs1_req", 64'(rf_rs1_req), 64'(1));
        chk("single_rs2_req", 64'(rf_rs2_req), 64'(1));
        chk("single_rs1_addr", 64'(rf_rs1_addr), 64'(3));
        chk("single_rs2_addr", 64'(rf_rs2_addr), 64'(7));
        chk("single_warp", 64'(rf_warp_id), 64'(5));
        cu_req_valid[0] = 1'b0;
        step();
        chk("single_grant_off", 64'(cu_grant), 64'(0));
        chk("single_req_off", 64'(rf_rs1_req), 64'(0));
        chk("single_early_v1", 64'(cu_rs1_valid), 64'(0));
        step();
        chk("single_v1", 64'(cu_rs1_valid), 64'(4'b0001));
        chk("single_v2", 64'(cu_rs2_valid), 64'(4'b0001));
        chk("single_err", 64'(err), 64'(0));
        step();
        chk("single_v1_off", 64'(cu_rs1_valid), 64'(0));
        chk("addr_hold", 64'(rf_rs1_addr), 64'(3));

        // Round-robin with all collectors requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) set_cu(i, 1'b1, WW'(i), 1'b1, AW'(10 + i), 1'b0, '0);
        for (int j = 1; j <= 8; j++) begin
            step();
            exp_idx = (j - 1) % 4;
            chk($sformatf("rr_grant_%0d", j), 64'(cu_grant), 64'(4'b0001 << exp_idx));
            chk($sformatf("rr_addr_%0d", j), 64'(rf_rs1_addr), 64'(10 + exp_idx));
            if (j >= 3)
                chk($sformatf("rr_v1_%0d", j), 64'(cu_rs1_valid), 64'(4'b0001 << ((j - 3) % 4)));
            else
                chk($sformatf("rr_v1_%0d", j), 64'(cu_rs1_valid), 64'(0));
        end
        cu_req_valid = '0;
        step();
        step();
        step();
        chk("rr_err", 64'(err), 64'(0));

        // Pipelined returns for collectors 1 and 2 (pointer is back at 0)
        set_cu(1, 1'b1, 5'd1, 1'b1, 5'd21, 1'b0, '0);
        set_cu(2, 1'b1, 5'd2, 1'b1, 5'd22, 1'b0, '0);
        step();
        chk("pipe_grant1", 64'(cu_grant), 64'(4'b0010));
        cu_req_valid[1] = 1'b0;
        step();
        chk("pipe_grant2", 64'(cu_grant), 64'(4'b0100));
        chk("pipe_addr2", 64'(rf_rs1_addr), 64'(22));
        cu_req_valid[2] = 1'b0;
        step();
        chk("pipe_v1_a", 64'(cu_rs1_valid), 64'(4'b0010));
        chk("pipe_v2_a", 64'(cu_rs2_valid), 64'(0));
        step();
        chk("pipe_v1_b", 64'(cu_rs1_valid), 64'(4'b0100));
        chk("pipe_v2_b", 64'(cu_rs2_valid), 64'(0));

        // No-operand request from collector 3, held high
        set_cu(3, 1'b1, 5'd9, 1'b0, 5'd1, 1'b0, 5'd2);
        step();
        chk("noop_grant", 64'(cu_grant), 64'(4'b1000));
        chk("noop_rs1_req", 64'(rf_rs1_req), 64'(0));
        chk("noop_rs2_req", 64'(rf_rs2_req), 64'(0));
        step();
        chk("noop_gap", 64'(cu_grant), 64'(0));
        step();
        chk("noop_regrant", 64'(cu_grant), 64'(4'b1000));
        chk("noop_v1", 64'(cu_rs1_valid), 64'(0));
        cu_req_valid[3] = 1'b0;
        step();
        chk("noop_v1_late", 64'(cu_rs1_valid | cu_rs2_valid), 64'(0));
        chk("noop_err", 64'(err), 64'(0));

        // Orphan rs2 return
        step();
        inj2 = 1'b1;
        step();
        inj2 = 1'b0;
        chk("orphan_err", 64'(err), 64'(1));
        step();
        step();
        chk("orphan_err_held", 64'(err), 64'(1));

        // Missing rs1 return
        do_reset();
        chk("err_cleared", 64'(err), 64'(0));
        set_cu(0, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, '0);
        step();
        chk("miss_grant", 64'(cu_grant), 64'(4'b0001));
        cu_req_valid[0] = 1'b0;
        sup1 = 1'b1;
        step();
        chk("miss_err_early", 64'(err), 64'(0));
        step();
        chk("miss_v1", 64'(cu_rs1_valid), 64'(0));
        step();
        sup1 = 1'b0;
        chk("miss_err", 64'(err), 64'(1));

        // Reset while two reads are in flight
        do_reset();
        set_cu(0, 1'b1, 5'd6, 1'b1, 5'd11, 1'b1, 5'd12);
        set_cu(1, 1'b1, 5'd7, 1'b1, 5'd13, 1'b1, 5'd14);
        step();
        chk("mid_grant0", 64'(cu_grant), 64'(4'b0001));
        step();
        chk("mid_grant1", 64'(cu_grant), 64'(4'b0010));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 64'(cu_grant), 64'(0));
        chk("mid_rst_req", 64'({rf_rs1_req, rf_rs2_req}), 64'(0));
        chk("mid_rst_addr", 64'({rf_rs1_addr, rf_rs2_addr, rf_warp_id}), 64'(0));
        chk("mid_rst_valid", 64'({cu_rs1_valid, cu_rs2_valid}), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("mid_first_grant", 64'(cu_grant), 64'(4'b0001));
        step();
        chk("mid_busy_cleared", 64'(cu_grant), 64'(4'b0010));
        cu_req_valid = '0;
        step();
        step();
        step();
        step();
        chk("mid_err", 64'(err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
